// File: rtl/mem_access_stage.sv
// ============================================================================
//  Module      : mem_access_stage
//  Description : EX/MEM register, big-endian load/store unit with a req/ack
//                data-memory handshake, and MEM/WB register. Optional REQ
//                timeout with bus error when MEM_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_busB_Rt,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic [1:0]  ex_size,
    input  logic        ex_sign,
    input  logic        ex_RegWrite,
    input  logic        ex_MemtoReg,
    input  logic [4:0]  ex_Rw,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] EXMEM_data,
    output logic [31:0] MEMWB_data,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_Rw,
    output logic        wb_RegWrite,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_REQ  = 1'b1;

    logic [31:0] r_exm_result;
    logic [31:0] r_exm_busb;
    logic        r_exm_memread;
    logic        r_exm_memwrite;
    logic [1:0]  r_exm_size;
    logic        r_exm_sign;
    logic        r_exm_regwrite;
    logic        r_exm_memtoreg;
    logic [4:0]  r_exm_rw;

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;

    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_aligned_op;
    logic        w_expire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_data;

    // ------------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exm_result   <= 32'h0;
            r_exm_busb     <= 32'h0;
            r_exm_memread  <= 1'b0;
            r_exm_memwrite <= 1'b0;
            r_exm_size     <= 2'b00;
            r_exm_sign     <= 1'b0;
            r_exm_regwrite <= 1'b0;
            r_exm_memtoreg <= 1'b0;
            r_exm_rw       <= 5'd0;
        end else if (!stall) begin
            r_exm_result   <= ex_result;
            r_exm_busb     <= ex_busB_Rt;
            r_exm_memread  <= ex_MemRead;
            r_exm_memwrite <= ex_MemWrite;
            r_exm_size     <= ex_size;
            r_exm_sign     <= ex_sign;
            r_exm_regwrite <= ex_RegWrite;
            r_exm_memtoreg <= ex_MemtoReg;
            r_exm_rw       <= ex_Rw;
        end
    end

    assign EXMEM_data = r_exm_result;

    // ------------------------------------------------------------------------
    // Alignment, byte enables and store-data lane replication
    // ------------------------------------------------------------------------
    always_comb begin
        w_mem_op     = r_exm_memread | r_exm_memwrite;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = r_exm_busb;
        case (r_exm_size)
            2'b00: begin
                w_be    = 4'b1000 >> r_exm_result[1:0];
                w_wdata = {4{r_exm_busb[7:0]}};
            end
            2'b01: begin
                w_misaligned = r_exm_result[0];
                w_be         = r_exm_result[1] ? 4'b0011 : 4'b1100;
                w_wdata      = {2{r_exm_busb[15:0]}};
            end
            default: begin
                w_misaligned = |r_exm_result[1:0];
            end
        endcase
        w_aligned_op = w_mem_op & ~w_misaligned;
    end

    // Load lane select: byte offset 0 lives in bits 31:24 (big-endian)
    always_comb begin
        w_lane_byte = 8'h00;
        case (r_exm_result[1:0])
            2'b00:   w_lane_byte = mem_rdata[31:24];
            2'b01:   w_lane_byte = mem_rdata[23:16];
            2'b10:   w_lane_byte = mem_rdata[15:8];
            default: w_lane_byte = mem_rdata[7:0];
        endcase
        w_lane_half = r_exm_result[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (r_exm_size)
            2'b00:   w_load_data = {{24{r_exm_sign & w_lane_byte[7]}}, w_lane_byte};
            2'b01:   w_load_data = {{16{r_exm_sign & w_lane_half[15]}}, w_lane_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------------
    // Optional REQ watchdog
    // ------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int c_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [c_CW-1:0] r_wait_cnt;
    logic            r_bus_err;

    always_ff @(posedge clk) begin
        if (reset || (r_state != c_REQ)) begin
            r_wait_cnt <= '0;
        end else if (!mem_ack) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // An ack in the expiry cycle takes priority over the timeout
    assign w_expire = (r_state == c_REQ) && !mem_ack &&
                      (r_wait_cnt == c_CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_expire;
        end
    end

    assign bus_err = r_bus_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_expire         = 1'b0;
    assign bus_err          = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Handshake FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake FSM: next state (stray acks in IDLE are ignored)
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_aligned_op) begin
                    w_next_state = c_REQ;
                end
            end
            default: begin
                if (mem_ack || w_expire) begin
                    w_next_state = c_IDLE;
                end
            end
        endcase
    end

    // Handshake FSM: combinational outputs
    always_comb begin
        stall        = w_aligned_op & ~((r_state == c_REQ) & (mem_ack | w_expire));
        misalign_err = w_mem_op & w_misaligned;
    end

    // ------------------------------------------------------------------------
    // Registered memory request; held stable for the whole REQ phase
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
        end else if ((r_state == c_IDLE) && w_aligned_op) begin
            mem_req   <= 1'b1;
            mem_we    <= r_exm_memwrite;
            mem_addr  <= {r_exm_result[31:2], 2'b00};
            mem_wdata <= w_wdata;
            mem_be    <= w_be;
        end else if ((r_state == c_REQ) && (mem_ack || w_expire)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // MEM/WB register: a stalled edge loads a bubble, data is kept
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data     <= 32'h0;
            wb_Rw       <= 5'd0;
            wb_RegWrite <= 1'b0;
        end else if (!stall) begin
            wb_data     <= r_exm_memtoreg ? w_load_data : r_exm_result;
            wb_Rw       <= r_exm_rw;
            wb_RegWrite <= r_exm_regwrite & ~misalign_err & ~w_expire;
        end else begin
            wb_RegWrite <= 1'b0;
        end
    end

    assign MEMWB_data = wb_data;

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

EX/MEM pipeline register plus load/store unit with a req/ack data-memory handshake, followed by the MEM/WB register. It consumes the execution stage's `result` and `busB_Rt`, performs byte, halfword or word loads and stores with big-endian lane steering, and stalls the pipeline while a memory access is outstanding. It drives the `EXMEM_data` and `MEMWB_data` forwarding buses back into the execution stage.

## Interface
Parameters:
- `TIMEOUT`, default 16: cycles in REQ without `mem_ack` before a bus error is declared. Only used when `MEM_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ex_result`  in  32  ALU result; used as the memory address or as the writeback value.
- `ex_busB_Rt`  in  32  store data.
- `ex_MemRead`, `ex_MemWrite`  in  1 each  load / store.
- `ex_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `ex_sign`  in  1  1 = sign-extend loads, 0 = zero-extend.
- `ex_RegWrite`, `ex_MemtoReg`  in  1 each  writeback controls.
- `ex_Rw`  in  5  destination register.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  word-aligned address (bits 1:0 forced to 00).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables; bit 3 = byte offset 0 = data bits 31:24.
- `mem_rdata`  in  32  read data.
- `mem_ack`  in  1  single-cycle completion.
- `stall`  out  1  freezes PC, IF/ID and ID/EX, and blocks EX/MEM capture.
- `EXMEM_data`  out  32  EX/MEM ALU result.
- `MEMWB_data`  out  32  `wb_data`.
- `wb_data`  out  32  writeback data.
- `wb_Rw`  out  5  writeback register.
- `wb_RegWrite`  out  1  writeback enable.
- `misalign_err`  out  1  one-cycle pulse.
- `bus_err`  out  1  one-cycle pulse.

## Operation
- **EX/MEM register:** captures all `ex_*` inputs each edge while `stall` = 0. Holds while `stall` = 1.
- **MEM/WB register:**
  - Captures every edge in which `stall` = 0.
  - While `stall` = 1, `wb_RegWrite` = 0 (bubble).
  - `wb_data` is the extended load data when MemtoReg, otherwise the EX/MEM result.
- **Alignment:**
  - A half access is misaligned when addr[0] = 1.
  - A word access is misaligned when addr[1:0] ≠ 00.
  - A misaligned op issues no request and produces no stall. `misalign_err` pulses in the cycle the op sits in EX/MEM, and its writeback is squashed (`wb_RegWrite` = 0).
- **FSM states:** IDLE, REQ.
  - IDLE → REQ when EX/MEM holds an aligned mem op that has not yet completed. `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are registered on this edge.
  - REQ with `mem_ack` → IDLE. Load data is extracted from `mem_rdata` and captured into MEM/WB on this edge, and EX/MEM advances.
  - REQ without `mem_ack` → REQ, outputs held stable.
- **Lane rules (big-endian):**
  - Byte at offset k uses `mem_be` = 1000 >> k.
  - Half at offset 0 uses `mem_be` = 1100; at offset 2 uses 0011.
  - Word uses 1111.
  - Stores replicate the byte or half across all lanes.
  - Loads select the lane and then sign- or zero-extend per `ex_sign`.
  - Loads drive `mem_we` = 0, and `mem_be` follows the same rule.
- **Stall:** `stall` = (aligned mem op in EX/MEM) AND NOT (state = REQ AND `mem_ack`). It is combinational.
- **Stray ack:** `mem_ack` in IDLE is ignored.
- **Non-memory ops:** pass through in 1 cycle with no stall.

## Timing
- **Reset values:** EX/MEM and MEM/WB control bits cleared; `mem_req`, `mem_we`, `stall`, `wb_RegWrite`, `misalign_err` and `bus_err` = 0; all data buses = 0; state = IDLE.
- **Zero-wait memory:** a memory op occupies EX/MEM for 2 cycles (1 stall cycle). Each wait cycle adds 1.
- **Non-memory op:** 1 cycle in EX/MEM.
- **`EXMEM_data`:** valid from the edge that captured the op.
- **`MEMWB_data`:** valid one edge later.
- **Reset mid-REQ:** `mem_req` is low after the reset edge, and no writeback of the pending op occurs. A late `mem_ack` is ignored.
- **Back-to-back memory ops:** the second op returns to REQ on the edge after the ack. `mem_req` is low for at least 1 cycle between requests.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - A counter runs in REQ.
  - If TIMEOUT cycles pass without `mem_ack`, then on the next edge `mem_req` drops, the state returns to IDLE, `bus_err` pulses for 1 cycle, the op retires with `wb_RegWrite` = 0, and `stall` releases.
  - An ack arriving in the same cycle as expiry wins: normal completion, no `bus_err`.
- **Undefined:**
  - No counter; REQ waits indefinitely.
  - `bus_err` is tied to 0.

## Test plan
- **Byte load:** lb from addr 0x103, `mem_rdata` = 0x11223380, ack in the first REQ cycle → `mem_be` = 0001, `wb_data` = 0xFFFFFF80. With lbu, `wb_data` = 0x00000080. Exactly 1 stall cycle.
- **Half store:** sh addr 0x202, `busB_Rt` = 0xDEADBEEF → `mem_addr` = 0x200, `mem_be` = 0011, `mem_wdata` = 0xBEEFBEEF, `mem_we` = 1, `wb_RegWrite` = 0.
- **Misaligned word:** lw at 0x101 → `misalign_err` pulse, `mem_req` never rises, `stall` = 0, no writeback.
- **Wait states:** ack after 3 cycles in REQ → `stall` high for 3 cycles, request outputs stable, `wb_data` = full word.
- **Reset during REQ:** after reset, `mem_req` = 0, state = IDLE, `wb_RegWrite` = 0, a late ack has no effect. With `MEM_TIMEOUT_EN` and `TIMEOUT` = 4, no ack → `bus_err` pulse and stall released.
